// File: rtl/trumpet_note_sequencer_if.sv
// trumpet_note_sequencer_if: control, ROM and audio-controller signals of the note sequencer
//   slave  : sequencer side (play/note_sel/audio_out_allowed/rom_q in; rom_addr, write strobe, samples, busy, note_done out)
//   master : environment side (mirror of slave)
interface trumpet_note_sequencer_if #(
  parameter int NOTE_W = 2,
  parameter int OFF_W  = 11,
  parameter int DATA_W = 3
);
  logic                    play;
  logic [NOTE_W-1:0]       note_sel;
  logic                    audio_out_allowed;
  logic [DATA_W-1:0]       rom_q;
  logic [NOTE_W+OFF_W-1:0] rom_addr;
  logic                    write_audio_out;
  logic [31:0]             left_channel_audio_out;
  logic [31:0]             right_channel_audio_out;
  logic                    busy;
  logic                    note_done;
  modport slave (
    input  play, note_sel, audio_out_allowed, rom_q,
    output rom_addr, write_audio_out, left_channel_audio_out, right_channel_audio_out, busy, note_done
  );
  modport master (
    output play, note_sel, audio_out_allowed, rom_q,
    input  rom_addr, write_audio_out, left_channel_audio_out, right_channel_audio_out, busy, note_done
  );
endinterface

// File: rtl/trumpet_note_sequencer.sv
// trumpet_note_sequencer: streams one ROM note region per play request into the audio controller, looping while play is held
//   CLOCK_50 : sole clock, rising edge
//   resetn   : synchronous active-low reset
//   bus      : slave modport carrying play/note_sel requests, ROM address/data and the audio write strobe/samples
module trumpet_note_sequencer #(
  parameter int NOTE_W   = 2,
  parameter int OFF_W    = 11,
  parameter int DATA_W   = 3,
  parameter int NOTE_LEN = 2000
) (
  input logic                      CLOCK_50,
  input logic                      resetn,
  trumpet_note_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, OUT} state_t;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(NOTE_LEN - 1);
  state_t            r_state, w_next;
  logic [NOTE_W-1:0] r_note;
  logic [OFF_W-1:0]  r_off;
  logic [31:0]       r_sample;
  logic              r_done;
  logic              w_wr, w_last;
  always_comb begin
    w_wr   = r_state == OUT && bus.audio_out_allowed;
    w_last = r_off == LAST_OFF;
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.play ? ADDR : IDLE;
      ADDR:    w_next = DATA;
      DATA:    w_next = OUT;
      OUT:     w_next = w_wr ? (bus.play ? ADDR : IDLE) : OUT;
      default: w_next = IDLE;
    endcase
  end
  // note_sel is only sampled when leaving IDLE or at a note boundary, so a note never changes region mid-way
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_note   <= '0;
      r_off    <= '0;
      r_sample <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_wr && w_last;
      if ((r_state == IDLE || (w_wr && w_last)) && bus.play) r_note <= bus.note_sel;
      if (r_state == IDLE || (w_wr && (w_last || !bus.play))) r_off <= '0;
      else if (w_wr) r_off <= r_off + 1'b1;
      if (r_state == DATA) r_sample <= {bus.rom_q, {(32-DATA_W){1'b0}}};
    end
  end
  // IDLE drives {note_sel, 0} so the ROM already holds the first word when play arrives
  assign bus.rom_addr                = r_state == IDLE ? {bus.note_sel, {OFF_W{1'b0}}} : {r_note, r_off};
  // strobes are gated with resetn so nothing leaks out during the reset cycle itself
  assign bus.write_audio_out         = w_wr && resetn;
  assign bus.note_done               = r_done && resetn;
  assign bus.busy                    = r_state != IDLE;
  assign bus.left_channel_audio_out  = r_state == IDLE ? 32'd0 : r_sample;
  assign bus.right_channel_audio_out = r_state == IDLE ? 32'd0 : r_sample;
endmodule

// File: tb/tb_trumpet_note_sequencer.sv
// tb_trumpet_note_sequencer: scoreboard bench for trumpet_note_sequencer with a registered ROM model
module tb_trumpet_note_sequencer;
  localparam int NOTE_W = 2, OFF_W = 11, DATA_W = 3, L = 12;
  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
    logic        last;
  } exp_t;
  logic  clk = 1'b0;
  logic  resetn = 1'b0;
  int    n_chk = 0, n_pass = 0, wr_cnt = 0;
  bit    done_pend = 1'b0;
  exp_t  q[$];
  exp_t  e;
  always #10 clk = ~clk;
  trumpet_note_sequencer_if #(.NOTE_W(NOTE_W), .OFF_W(OFF_W), .DATA_W(DATA_W)) bus ();
  trumpet_note_sequencer #(.NOTE_W(NOTE_W), .OFF_W(OFF_W), .DATA_W(DATA_W), .NOTE_LEN(L)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );
  function automatic logic [2:0] rom_val(logic [12:0] a);
    logic [2:0] v;
    v = a[2:0] + {1'b0, a[12:11]} * 3'd3 + 3'd1;
    return v;
  endfunction
  always @(posedge clk) bus.rom_q <= rom_val(bus.rom_addr);
  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask
  task automatic push_note(int note, int n, bit full);
    logic [12:0] a;
    for (int o = 0; o < n; o++) begin
      a = {note[1:0], 11'(o)};
      q.push_back('{a, {rom_val(a), 29'd0}, full && o == L - 1});
    end
  endtask
  task automatic wait_wr(int n);
    int t = 0;
    while (!(bus.write_audio_out === 1'b1 && wr_cnt == n) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 300) chk("wait_wr_timeout", 64'(t), 64'(0));
  endtask
  always @(negedge clk) begin
    if (done_pend) begin
      chk("note_done", bus.note_done, 1);
      done_pend = 1'b0;
    end else if (bus.note_done === 1'b1) chk("spurious_note_done", bus.note_done, 0);
    if (bus.write_audio_out === 1'b1) begin
      wr_cnt++;
      if (q.size() == 0) chk("unexpected_write", bus.write_audio_out, 0);
      else begin
        e = q.pop_front();
        chk("wr_addr", bus.rom_addr, e.addr);
        chk("wr_left", bus.left_channel_audio_out, e.data);
        chk("wr_right", bus.right_channel_audio_out, e.data);
        done_pend = e.last;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, bad, wrs;
    logic [12:0] snap_a;
    logic [31:0] snap_l;
    bus.play = 1'b0;
    bus.note_sel = 2'd2;
    bus.audio_out_allowed = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr", bus.write_audio_out, 0);
    chk("rst_done", bus.note_done, 0);
    chk("rst_left", bus.left_channel_audio_out, 0);
    chk("rst_addr", bus.rom_addr, 13'h1000);
    push_note(2, L, 1);
    push_note(1, L, 1);
    push_note(3, 11, 0);
    resetn = 1'b1;
    bus.play = 1'b1;
    lat = 0;
    while (bus.write_audio_out !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("first_wr_lat", 64'(lat), 64'(3));
    chk("first_wr_addr", bus.rom_addr, 13'h1000);
    wait_wr(5);
    bus.note_sel = 2'd1;
    wait_wr(17);
    bus.note_sel = 2'd3;
    wait_wr(27);
    @(posedge clk);
    #1;
    bus.audio_out_allowed = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("bp_busy", bus.busy, 1);
    chk("bp_wr", bus.write_audio_out, 0);
    chk("bp_left", bus.left_channel_audio_out, {rom_val(13'h1804), 29'd0});
    snap_a = bus.rom_addr;
    snap_l = bus.left_channel_audio_out;
    bad = 0;
    wrs = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.write_audio_out !== 1'b0) wrs++;
      if (bus.rom_addr !== snap_a || bus.left_channel_audio_out !== snap_l || bus.busy !== 1'b1) bad++;
    end
    chk("bp_no_write", 64'(wrs), 64'(0));
    chk("bp_stable", 64'(bad), 64'(0));
    bus.audio_out_allowed = 1'b1;
    #1;
    chk("bp_release_wr", bus.write_audio_out, 1);
    @(posedge clk);
    #1;
    chk("bp_single_wr", bus.write_audio_out, 0);
    wait_wr(34);
    bus.play = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_left", bus.left_channel_audio_out, 0);
    chk("abort_addr", bus.rom_addr, 13'h1800);
    repeat (5) @(posedge clk);
    #1;
    bus.note_sel = 2'd0;
    bus.play = 1'b1;
    bus.audio_out_allowed = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", bus.busy, 1);
    resetn = 1'b0;
    bus.audio_out_allowed = 1'b1;
    bus.note_sel = 2'd1;
    #1;
    chk("rst_out_wr", bus.write_audio_out, 0);
    chk("rst_out_done", bus.note_done, 0);
    @(posedge clk);
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_left", bus.left_channel_audio_out, 0);
    chk("rst_mid_addr", bus.rom_addr, 13'h0800);
    resetn = 1'b1;
    bus.play = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", bus.busy, 0);
    push_note(1, L, 1);
    bus.play = 1'b1;
    wait_wr(46);
    bus.play = 1'b0;
    @(posedge clk);
    #1;
    chk("final_idle", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(q.size()), 64'(0));
    chk("wr_total", 64'(wr_cnt), 64'(47));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
